// File: rtl/icache_ctrl_mb_pkg.sv
// Shared register offsets, FSM state type and constants for the multi-bank icache controller.
package icache_ctrl_mb_pkg;

    // Word offsets, i.e. add[7:2]
    localparam logic [5:0] REG_ENABLE    = 6'h00;
    localparam logic [5:0] REG_FLUSH     = 6'h01;
    localparam logic [5:0] REG_SEL_FLUSH = 6'h02;
    localparam logic [5:0] REG_STATUS    = 6'h03;
    localparam logic [5:0] REG_CLEAR     = 6'h04;
    localparam logic [5:0] REG_CNT_EN    = 6'h05;

    localparam logic [1:0] REG_HIT_PAGE   = 2'b01;
    localparam logic [1:0] REG_TRANS_PAGE = 2'b10;

    localparam logic [31:0] BADD_DATA = 32'hBADD_A555;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYP,
        WAIT_FL,
        WAIT_SEL,
        DONE
    } state_e;

endpackage

// File: rtl/icache_ctrl_unit_mb_if.sv
// Peripheral slave bus used by the icache controller.
// Handshake: a request is accepted on a rising edge where req and gnt are both 1; exactly one
// r_valid pulse (carrying the accepted id in r_id) follows each accepted request.
interface icache_ctrl_unit_mb_if #(
    parameter int ID_WIDTH = 9
) ();
    logic                req;
    logic [31:0]         add;
    logic                wen;
    logic [31:0]         wdata;
    logic [3:0]          be;
    logic [ID_WIDTH-1:0] id;
    logic                gnt;
    logic                r_valid;
    logic                r_opc;
    logic [ID_WIDTH-1:0] r_id;
    logic [31:0]         r_rdata;

    modport master (
        output req, add, wen, wdata, be, id,
        input  gnt, r_valid, r_opc, r_id, r_rdata
    );

    modport slave (
        input  req, add, wen, wdata, be, id,
        output gnt, r_valid, r_opc, r_id, r_rdata
    );
endinterface

// File: rtl/icache_stat_cnt_bank.sv
// Per-core saturating hit and transaction counters with synchronous clear and a core-indexed read mux.
module icache_stat_cnt_bank #(
    parameter int NB_CORES  = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear,
    input  logic                enable,
    input  logic [NB_CORES-1:0] hit_evt,
    input  logic [NB_CORES-1:0] trans_evt,
    input  logic [3:0]          rd_core,
    output logic [31:0]         hit_rdata,
    output logic [31:0]         trans_rdata
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] hit_cnt   [NB_CORES];
    logic [CNT_WIDTH-1:0] trans_cnt [NB_CORES];

    // Clear has priority so an event in the clearing cycle is dropped
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NB_CORES; c++) begin
                hit_cnt[c]   <= '0;
                trans_cnt[c] <= '0;
            end
        end else if (clear) begin
            for (int c = 0; c < NB_CORES; c++) begin
                hit_cnt[c]   <= '0;
                trans_cnt[c] <= '0;
            end
        end else if (enable) begin
            for (int c = 0; c < NB_CORES; c++) begin
                if (hit_evt[c] && hit_cnt[c] != CNT_MAX) begin
                    hit_cnt[c] <= hit_cnt[c] + CNT_WIDTH'(1);
                end
                if (trans_evt[c] && trans_cnt[c] != CNT_MAX) begin
                    trans_cnt[c] <= trans_cnt[c] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        hit_rdata   = '0;
        trans_rdata = '0;
        for (int c = 0; c < NB_CORES; c++) begin
            if (rd_core == 4'(c)) begin
                hit_rdata   = 32'(hit_cnt[c]);
                trans_rdata = 32'(trans_cnt[c]);
            end
        end
    end
endmodule

// File: rtl/icache_ctrl_unit_mb.sv
// Multi-bank icache control unit: bank enable/flush handshakes, selective flush and per-core counters
// behind a 32-bit peripheral slave port.
module icache_ctrl_unit_mb
    import icache_ctrl_mb_pkg::*;
#(
    parameter int NB_BANKS  = 8,
    parameter int NB_CORES  = 8,
    parameter int ID_WIDTH  = 9,
    parameter int CNT_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    icache_ctrl_unit_mb_if.slave  bus,
    output logic [NB_BANKS-1:0]   bypass_req_o,
    input  logic [NB_BANKS-1:0]   bypass_ack_i,
    output logic [NB_BANKS-1:0]   flush_req_o,
    input  logic [NB_BANKS-1:0]   flush_ack_i,
    output logic                  sel_flush_req_o,
    output logic [31:0]           sel_flush_addr_o,
    input  logic                  sel_flush_ack_i,
    input  logic [NB_CORES-1:0]   hit_evt_i,
    input  logic [NB_CORES-1:0]   trans_evt_i,
    output state_e                state_dbg
);
    state_e               state;
    logic [NB_BANKS-1:0]  en_mask;
    logic [NB_BANKS-1:0]  pending;
    logic [NB_BANKS-1:0]  pending_next;
    logic [NB_BANKS-1:0]  status;
    logic                 cnt_en;
    logic                 r_valid_q;
    logic                 r_opc_q;
    logic [ID_WIDTH-1:0]  r_id_q;
    logic [31:0]          r_rdata_q;
    logic [31:0]          rd_word;
    logic [31:0]          hit_rdata;
    logic [31:0]          trans_rdata;
    logic [5:0]           idx;
    logic [3:0]           core;
    logic                 core_ok;
    logic                 is_hit;
    logic                 is_trans;
    logic                 grant;
    logic                 clear_cnt;
    logic                 unused_bits;

    assign idx          = bus.add[7:2];
    assign core         = idx[3:0];
    assign core_ok      = int'(core) < NB_CORES;
    assign is_hit       = (idx[5:4] == REG_HIT_PAGE) && core_ok;
    assign is_trans     = (idx[5:4] == REG_TRANS_PAGE) && core_ok;
    assign grant        = bus.req && (state == IDLE);
    assign clear_cnt    = grant && !bus.wen && (idx == REG_CLEAR);
    assign status       = ~bypass_ack_i;
    assign pending_next = pending & ~flush_ack_i;
    assign unused_bits  = ^{bus.be, bus.add[31:8], bus.add[1:0]};

    assign bus.gnt     = grant;
    assign bus.r_valid = r_valid_q;
    assign bus.r_opc   = r_opc_q;
    assign bus.r_id    = r_id_q;
    assign bus.r_rdata = r_rdata_q;
    assign state_dbg   = state;

    always_comb begin
        rd_word = BADD_DATA;
        if (is_hit) begin
            rd_word = hit_rdata;
        end else if (is_trans) begin
            rd_word = trans_rdata;
        end else begin
            case (idx)
                REG_ENABLE: rd_word = 32'(en_mask);
                REG_STATUS: rd_word = 32'(status);
                REG_CNT_EN: rd_word = {31'b0, cnt_en};
                default:    rd_word = BADD_DATA;
            endcase
        end
    end

    // Single-cycle accesses answer straight from IDLE; handshake writes answer via DONE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state            <= IDLE;
            en_mask          <= '0;
            bypass_req_o     <= '1;
            flush_req_o      <= '0;
            pending          <= '0;
            sel_flush_req_o  <= 1'b0;
            sel_flush_addr_o <= '0;
            cnt_en           <= 1'b0;
            r_valid_q        <= 1'b0;
            r_opc_q          <= 1'b0;
            r_id_q           <= '0;
            r_rdata_q        <= '0;
        end else begin
            r_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        r_id_q <= bus.id;
                        if (bus.wen) begin
                            r_valid_q <= 1'b1;
                            r_opc_q   <= 1'b0;
                            r_rdata_q <= rd_word;
                        end else begin
                            r_rdata_q <= '0;
                            case (idx)
                                REG_ENABLE: begin
                                    en_mask      <= bus.wdata[NB_BANKS-1:0];
                                    bypass_req_o <= ~bus.wdata[NB_BANKS-1:0];
                                    state        <= WAIT_BYP;
                                end
                                REG_FLUSH: begin
                                    flush_req_o <= bus.wdata[NB_BANKS-1:0];
                                    pending     <= bus.wdata[NB_BANKS-1:0];
                                    state       <= WAIT_FL;
                                end
                                REG_SEL_FLUSH: begin
                                    sel_flush_addr_o <= bus.wdata;
                                    sel_flush_req_o  <= 1'b1;
                                    state            <= WAIT_SEL;
                                end
                                REG_CLEAR: begin
                                    r_valid_q <= 1'b1;
                                    r_opc_q   <= 1'b0;
                                end
                                REG_CNT_EN: begin
                                    cnt_en    <= bus.wdata[0];
                                    r_valid_q <= 1'b1;
                                    r_opc_q   <= 1'b0;
                                end
                                default: begin
                                    r_valid_q <= 1'b1;
                                    r_opc_q   <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                WAIT_BYP: begin
                    if (bypass_ack_i == bypass_req_o) begin
                        state     <= DONE;
                        r_valid_q <= 1'b1;
                        r_opc_q   <= 1'b0;
                    end
                end
                WAIT_FL: begin
                    flush_req_o <= flush_req_o & ~flush_ack_i;
                    pending     <= pending_next;
                    if (pending_next == '0) begin
                        state     <= DONE;
                        r_valid_q <= 1'b1;
                        r_opc_q   <= 1'b0;
                    end
                end
                WAIT_SEL: begin
                    if (sel_flush_ack_i) begin
                        sel_flush_req_o <= 1'b0;
                        state           <= DONE;
                        r_valid_q       <= 1'b1;
                        r_opc_q         <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    icache_stat_cnt_bank #(
        .NB_CORES  (NB_CORES),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear       (clear_cnt),
        .enable      (cnt_en),
        .hit_evt     (hit_evt_i),
        .trans_evt   (trans_evt_i),
        .rd_core     (core),
        .hit_rdata   (hit_rdata),
        .trans_rdata (trans_rdata)
    );
endmodule

// File: tb/tb_icache_ctrl_unit_mb.sv
// Directed bench for icache_ctrl_unit_mb: register table plus bypass, flush, selective-flush, counter and reset sequences.
module tb_icache_ctrl_unit_mb;
    import icache_ctrl_mb_pkg::*;

    logic        clk;
    logic        rst_ni;
    logic [7:0]  bypass_req;
    logic [7:0]  bypass_ack;
    logic [7:0]  flush_req;
    logic [7:0]  flush_ack;
    logic        sel_req;
    logic [31:0] sel_addr;
    logic        sel_ack;
    logic [7:0]  hit_evt;
    logic [7:0]  trans_evt;
    state_e      dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [8:0]  next_id = 9'h010;
    logic [31:0] exp_q[$];

    typedef struct {
        string       name;
        logic [31:0] add;
        logic        wen;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_opc;
    } vec_t;

    vec_t vecs[9];

    icache_ctrl_unit_mb_if #(.ID_WIDTH(9)) bus ();

    icache_ctrl_unit_mb #(
        .NB_BANKS  (8),
        .NB_CORES  (8),
        .ID_WIDTH  (9),
        .CNT_WIDTH (4)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .bus              (bus),
        .bypass_req_o     (bypass_req),
        .bypass_ack_i     (bypass_ack),
        .flush_req_o      (flush_req),
        .flush_ack_i      (flush_ack),
        .sel_flush_req_o  (sel_req),
        .sel_flush_addr_o (sel_addr),
        .sel_flush_ack_i  (sel_ack),
        .hit_evt_i        (hit_evt),
        .trans_evt_i      (trans_evt),
        .state_dbg        (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Driver: present a request, returns at posedge+1 of the first cycle after the grant
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [8:0] id);
        int n;
        bus.req   = 1'b1;
        bus.add   = a;
        bus.wen   = w;
        bus.wdata = d;
        bus.id    = id;
        n = 0;
        @(negedge clk);
        while (!bus.gnt && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.gnt) begin
            checks++;
            failures++;
            $display("FAIL gnt_timeout actual=0 expected=1");
        end
        @(posedge clk);
        #1;
        bus.req = 1'b0;
    endtask

    task automatic wait_resp(output int lat, output logic [31:0] rd, output logic opc, output logic [8:0] rid);
        lat = 1;
        @(negedge clk);
        while (!bus.r_valid && lat < 30) begin
            step();
            @(negedge clk);
            lat++;
        end
        if (!bus.r_valid) lat = -1;
        rd  = bus.r_rdata;
        opc = bus.r_opc;
        rid = bus.r_id;
        step();
    endtask

    // Single-cycle access: expected data goes through the scoreboard queue
    task automatic do_access(input string name, input logic [31:0] a, input logic w,
                             input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_opc);
        int          lat;
        logic [31:0] rd;
        logic        opc;
        logic [8:0]  rid;
        logic [8:0]  id;
        id = next_id;
        next_id++;
        exp_q.push_back(exp_rd);
        issue(a, w, d, id);
        wait_resp(lat, rd, opc, rid);
        check({name, "_lat"}, 32'(lat), 32'd1);
        check({name, "_rdata"}, rd, exp_q.pop_front());
        check({name, "_opc"}, {31'b0, opc}, {31'b0, exp_opc});
        check({name, "_rid"}, 32'(rid), 32'(id));
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        opc;
        logic [8:0]  rid;

        vecs[0] = '{"rd_status",    32'h0C, 1'b1, 32'h0,        32'h0000_0000, 1'b0};
        vecs[1] = '{"rd_enable",    32'h00, 1'b1, 32'h0,        32'h0000_0000, 1'b0};
        vecs[2] = '{"rd_cnt_en",    32'h14, 1'b1, 32'h0,        32'h0000_0000, 1'b0};
        vecs[3] = '{"rd_unmapped",  32'hFC, 1'b1, 32'h0,        32'hBADD_A555, 1'b0};
        vecs[4] = '{"wr_unmapped",  32'h18, 1'b0, 32'h1234,     32'h0000_0000, 1'b1};
        vecs[5] = '{"rd_hit3",      32'h4C, 1'b1, 32'h0,        32'h0000_0000, 1'b0};
        vecs[6] = '{"rd_flush_reg", 32'h04, 1'b1, 32'h0,        32'hBADD_A555, 1'b0};
        vecs[7] = '{"wr_status",    32'h0C, 1'b0, 32'hFF,       32'h0000_0000, 1'b1};
        vecs[8] = '{"wr_counter",   32'h4C, 1'b0, 32'h7,        32'h0000_0000, 1'b1};

        rst_ni     = 1'b0;
        bus.req    = 1'b0;
        bus.add    = '0;
        bus.wen    = 1'b1;
        bus.wdata  = '0;
        bus.be     = 4'hF;
        bus.id     = '0;
        bypass_ack = 8'hFF;
        flush_ack  = 8'h00;
        sel_ack    = 1'b0;
        hit_evt    = '0;
        trans_evt  = '0;
        repeat (3) @(negedge clk);
        check("rst_bypass_req", 32'(bypass_req), 32'hFF);
        check("rst_flush_req", 32'(flush_req), 32'h0);
        check("rst_sel_req", {31'b0, sel_req}, 32'h0);
        check("rst_sel_addr", sel_addr, 32'h0);
        check("rst_r_valid", {31'b0, bus.r_valid}, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_ni = 1'b1;
        step();

        foreach (vecs[i]) begin
            do_access(vecs[i].name, vecs[i].add, vecs[i].wen, vecs[i].wdata,
                      vecs[i].exp_rdata, vecs[i].exp_opc);
        end

        // Enable banks 0-3: bypass ack arrives after 5 cycles, no grant meanwhile
        issue(32'h00, 1'b0, 32'h0F, 9'h1A5);
        for (int t = 1; t <= 5; t++) begin
            bus.req = 1'b1;
            bus.add = 32'h0C;
            bus.wen = 1'b1;
            @(negedge clk);
            if (t == 1) check("byp_req", 32'(bypass_req), 32'hF0);
            check("byp_gnt_blocked", {31'b0, bus.gnt}, 32'h0);
            check("byp_no_resp", {31'b0, bus.r_valid}, 32'h0);
            step();
        end
        bus.req    = 1'b0;
        bypass_ack = 8'hF0;
        @(negedge clk);
        check("byp_ack_cycle_no_resp", {31'b0, bus.r_valid}, 32'h0);
        check("byp_state", 32'(dbg_state), 32'(WAIT_BYP));
        step();
        @(negedge clk);
        check("byp_resp", {31'b0, bus.r_valid}, 32'h1);
        check("byp_rid", 32'(bus.r_id), 32'h1A5);
        check("byp_opc", {31'b0, bus.r_opc}, 32'h0);
        step();
        @(negedge clk);
        check("byp_resp_single", {31'b0, bus.r_valid}, 32'h0);
        step();
        do_access("rd_enable_0f", 32'h00, 1'b1, 32'h0, 32'h0000_000F, 1'b0);
        do_access("rd_status_0f", 32'h0C, 1'b1, 32'h0, 32'h0000_000F, 1'b0);

        // Flush banks 0 and 2 with staggered acks
        issue(32'h04, 1'b0, 32'h05, 9'h042);
        for (int t = 1; t <= 8; t++) begin
            flush_ack = (t == 3) ? 8'h01 : (t == 7) ? 8'h04 : 8'h00;
            @(negedge clk);
            check($sformatf("fl_req_t%0d", t), 32'(flush_req),
                  (t <= 3) ? 32'h05 : (t <= 7) ? 32'h04 : 32'h00);
            check($sformatf("fl_resp_t%0d", t), {31'b0, bus.r_valid}, (t == 8) ? 32'h1 : 32'h0);
            step();
        end
        flush_ack = 8'h00;

        // Empty flush mask answers two cycles after the grant
        issue(32'h04, 1'b0, 32'h00, 9'h043);
        @(negedge clk);
        check("fl0_resp_c1", {31'b0, bus.r_valid}, 32'h0);
        step();
        @(negedge clk);
        check("fl0_resp_c2", {31'b0, bus.r_valid}, 32'h1);
        step();

        // Selective flush held until ack, then one response
        issue(32'h08, 1'b0, 32'h1C00_0100, 9'h044);
        for (int t = 1; t <= 6; t++) begin
            sel_ack = (t == 4);
            @(negedge clk);
            check($sformatf("sel_req_t%0d", t), {31'b0, sel_req}, (t <= 4) ? 32'h1 : 32'h0);
            check($sformatf("sel_resp_t%0d", t), {31'b0, bus.r_valid}, (t == 5) ? 32'h1 : 32'h0);
            if (t == 1) check("sel_addr", sel_addr, 32'h1C00_0100);
            step();
        end
        sel_ack = 1'b0;

        // Counters: 10 hits and 12 transactions on core 3
        do_access("wr_cnt_en", 32'h14, 1'b0, 32'h1, 32'h0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            hit_evt   = (i < 10) ? 8'h08 : 8'h00;
            trans_evt = 8'h08;
            step();
        end
        hit_evt   = '0;
        trans_evt = '0;
        do_access("rd_hit3_10", 32'h4C, 1'b1, 32'h0, 32'd10, 1'b0);
        do_access("rd_trans3_12", 32'h8C, 1'b1, 32'h0, 32'd12, 1'b0);
        do_access("rd_hit2_0", 32'h48, 1'b1, 32'h0, 32'd0, 1'b0);

        // Clear with an event in the grant cycle: clear wins
        hit_evt   = 8'h08;
        trans_evt = 8'h08;
        issue(32'h10, 1'b0, 32'h0, 9'h050);
        hit_evt   = '0;
        trans_evt = '0;
        wait_resp(lat, rd, opc, rid);
        check("clr_lat", 32'(lat), 32'd1);
        check("clr_opc", {31'b0, opc}, 32'h0);
        do_access("rd_hit3_clr", 32'h4C, 1'b1, 32'h0, 32'd0, 1'b0);
        do_access("rd_trans3_clr", 32'h8C, 1'b1, 32'h0, 32'd0, 1'b0);

        // Saturation at 4 bits
        for (int i = 0; i < 20; i++) begin
            hit_evt = 8'h08;
            step();
        end
        hit_evt = '0;
        do_access("rd_hit3_sat", 32'h4C, 1'b1, 32'h0, 32'd15, 1'b0);

        // Disabled counters ignore events
        do_access("wr_cnt_dis", 32'h14, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            trans_evt = 8'h08;
            step();
        end
        trans_evt = '0;
        do_access("rd_trans3_dis", 32'h8C, 1'b1, 32'h0, 32'd0, 1'b0);
        do_access("rd_cnt_en_0", 32'h14, 1'b1, 32'h0, 32'd0, 1'b0);

        // Reset while waiting on flush acks
        issue(32'h04, 1'b0, 32'hFF, 9'h060);
        @(negedge clk);
        check("rstfl_state_wait", 32'(dbg_state), 32'(WAIT_FL));
        check("rstfl_req_before", 32'(flush_req), 32'hFF);
        step();
        rst_ni = 1'b0;
        #1;
        check("rstfl_flush_req", 32'(flush_req), 32'h00);
        check("rstfl_bypass_req", 32'(bypass_req), 32'hFF);
        check("rstfl_state", 32'(dbg_state), 32'(IDLE));
        check("rstfl_r_valid", {31'b0, bus.r_valid}, 32'h0);
        step();
        rst_ni = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("rstfl_no_resp", {31'b0, bus.r_valid}, 32'h0);
            check("rstfl_idle", 32'(dbg_state), 32'(IDLE));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
